// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   mem_state_t : memory wait-state FSM encoding
//   sb_entry_t  : per-stage destination scoreboard entry
package hazard_pkg;

    // Scoreboard rd field width; covers any REG_AW up to 8.
    localparam int unsigned SB_RD_W   = 8;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned DEC_STAGE = 1;
    localparam int unsigned REG_ZERO  = 0;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [SB_RD_W-1:0] rd;
        logic               wr_en;
        logic               is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Priority encoder over the producer scoreboard for one decode source.
//   valid_i    : valid bits of producer stages 2..NUM_STAGES-1
//   sb_i       : scoreboard entries of producer stages
//   src_i      : decode source register, src_en_i : source is read
//   sel_o      : 0 = regfile, k = forward from stage 1+k (nearest match)
//   load_hit_o : nearest match is a load not yet in the last stage
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned SEL_W      = 2
) (
    input  logic [NUM_STAGES-1:2]      valid_i,
    input  sb_entry_t [NUM_STAGES-1:2] sb_i,
    input  logic [REG_AW-1:0]          src_i,
    input  logic                       src_en_i,
    output logic [SEL_W-1:0]           sel_o,
    output logic                       load_hit_o
);

    // Walk from the oldest stage to the youngest so the nearest match wins.
    always_comb begin
        sel_o      = '0;
        load_hit_o = 1'b0;
        for (int s = int'(NUM_STAGES) - 1; s >= 2; s--) begin
            if (valid_i[s] && sb_i[s].wr_en && src_en_i &&
                (sb_i[s].rd == SB_RD_W'(src_i)) &&
                (src_i != REG_AW'(REG_ZERO))) begin
                sel_o      = SEL_W'(s - 1);
                load_hit_o = sb_i[s].is_load && (s < int'(NUM_STAGES) - 1);
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline control for an N-stage RV32 pipeline.
// Stage 0 = fetch, stage 1 = decode, stage NUM_STAGES-1 = memory/writeback.
// Tracks stage valid bits and a destination scoreboard; produces forwarding
// selects, load-use bubbles, redirect flushes and memory wait-state freezes.
//   CLK, Reset                : clock, synchronous active-high reset
//   if_valid                  : fetch holds a valid instruction
//   dec_*                     : decode-stage instruction fields
//   redirect                  : taken branch/jump resolved in decode
//   mem_req / mem_ack         : last-stage memory access / completion
//   stage_en, stage_valid     : per-stage load enable / valid bit
//   pc_en, flush              : PC advance / redirect accepted
//   fwd_sel1, fwd_sel2        : forwarding selects for rs1 / rs2
//   load_stall, mem_stall     : bubble inserted / pipeline frozen
// Optional MEM_TIMEOUT_EN: adds TIMEOUT_CYC wait limit and mem_err pulse.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned SEL_W       = $clog2(NUM_STAGES)
`ifdef MEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  if_valid,
    input  logic [REG_AW-1:0]     dec_rs1,
    input  logic [REG_AW-1:0]     dec_rs2,
    input  logic                  dec_rs1_en,
    input  logic                  dec_rs2_en,
    input  logic [REG_AW-1:0]     dec_rd,
    input  logic                  dec_wr_en,
    input  logic                  dec_is_load,
    input  logic                  redirect,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  pc_en,
    output logic                  flush,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [SEL_W-1:0]      fwd_sel2,
    output logic                  load_stall,
    output logic                  mem_stall
`ifdef MEM_TIMEOUT_EN
    , output logic                mem_err
`endif
);

    localparam int unsigned LAST = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0]      valid_q, valid_d;
    sb_entry_t [NUM_STAGES-1:2] sb_q, sb_d;
    mem_state_t                 state_q;

    logic [SEL_W-1:0] sel1_c, sel2_c;
    logic             lhit1_c, lhit2_c;
    logic             timeout_c;
    logic             mstall_c, lstall_c, flush_c;

    // Source match for rs1 and rs2.
    hazard_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_match_rs1 (
        .valid_i    (valid_q[LAST:2]),
        .sb_i       (sb_q),
        .src_i      (dec_rs1),
        .src_en_i   (dec_rs1_en),
        .sel_o      (sel1_c),
        .load_hit_o (lhit1_c)
    );

    hazard_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_match_rs2 (
        .valid_i    (valid_q[LAST:2]),
        .sb_i       (sb_q),
        .src_i      (dec_rs2),
        .src_en_i   (dec_rs2_en),
        .sel_o      (sel2_c),
        .load_hit_o (lhit2_c)
    );

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;

    // Wait-cycle counter: counts M_WAIT cycles, saturates, clears on exit.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if ((state_q == M_WAIT) && !mem_ack && !timeout_c) begin
            if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout_c = !Reset && (state_q == M_WAIT) && !mem_ack &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC));
    assign mem_err   = timeout_c;
`else
    assign timeout_c = 1'b0;
`endif

    // Stall and flush arbitration: mem_stall > load_stall > redirect.
    always_comb begin
        mstall_c = !Reset && !mem_ack && !timeout_c &&
                   (((state_q == M_IDLE) && valid_q[LAST] && mem_req) ||
                    (state_q == M_WAIT));
        lstall_c = !Reset && !mstall_c && valid_q[DEC_STAGE] &&
                   (lhit1_c || lhit2_c);
        flush_c  = !Reset && !mstall_c && !lstall_c && redirect &&
                   valid_q[DEC_STAGE];
    end

    // Control outputs; all quiet except pc_en while Reset is high.
    always_comb begin
        stage_en = '1;
        if (Reset || mstall_c) begin
            stage_en = '0;
        end else if (lstall_c) begin
            stage_en[0] = 1'b0;
            stage_en[1] = 1'b0;
        end
        pc_en       = Reset || !(mstall_c || lstall_c);
        flush       = flush_c;
        load_stall  = lstall_c;
        mem_stall   = mstall_c;
        stage_valid = Reset ? '0 : valid_q;
        fwd_sel1    = Reset ? '0 : sel1_c;
        fwd_sel2    = Reset ? '0 : sel2_c;
    end

    // Next valid bits and scoreboard; frozen entirely during mem_stall.
    always_comb begin
        valid_d = valid_q;
        sb_d    = sb_q;
        if (!mstall_c) begin
            if (!lstall_c) begin
                valid_d[0] = if_valid;
                valid_d[1] = valid_q[0] && !flush_c;
            end
            // A load-use bubble enters stage 2 as an invalid, non-writing slot.
            valid_d[2]       = valid_q[1] && !lstall_c;
            sb_d[2].rd       = SB_RD_W'(dec_rd);
            sb_d[2].wr_en    = dec_wr_en && !lstall_c;
            sb_d[2].is_load  = dec_is_load;
            for (int s = 3; s < int'(NUM_STAGES); s++) begin
                valid_d[s] = valid_q[s-1];
                sb_d[s]    = sb_q[s-1];
            end
            // A timed-out access drops the instruction in the last stage.
            if (timeout_c) begin
                valid_d[LAST] = 1'b0;
            end
        end
    end

    // Valid and scoreboard registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            valid_q <= '0;
            sb_q    <= '0;
        end else begin
            valid_q <= valid_d;
            sb_q    <= sb_d;
        end
    end

    // Memory wait-state FSM; a same-cycle ack never enters M_WAIT.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= M_IDLE;
        end else begin
            case (state_q)
                M_IDLE: begin
                    if (valid_q[LAST] && mem_req && !mem_ack) begin
                        state_q <= M_WAIT;
                    end
                end
                M_WAIT: begin
                    if (mem_ack || timeout_c) begin
                        state_q <= M_IDLE;
                    end
                end
                default: state_q <= M_IDLE;
            endcase
        end
    end

endmodule
